// File: rtl/gemm_tile_scheduler.sv
// gemm_tile_scheduler
//   Walks the M x K x N tile space of an output-stationary 4x4 MAC array
//   (K innermost, then N, then M). It issues one A/B SRAM tile read per
//   un-stalled RUN cycle. It drives the PE valid/init_save/acc_clr controls
//   one cycle behind each issue, to match the 1-cycle SRAM latency. Once per
//   output tile it raises the C write strobe, two cycles after the issue of
//   the last K slice.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i                 start pulse; size inputs sampled on the same edge
//   M/K/N_size_i            problem sizes in elements
//   stall_i                 freeze issue while memory is not ready
//   sram_a/b_addr_o         A row-tile / B column-tile read addresses
//   sram_c_addr_o/_we_o     C tile write address and strobe
//   pe_valid_o              PE operand valid
//   pe_init_save_o          first K slice of an output tile
//   pe_acc_clr_o            accumulator clear while idle
//   busy_o, done_o          run in progress / one-cycle completion pulse
module gemm_tile_scheduler #(
    parameter int unsigned SizeAddrWidth = 8,
    parameter int unsigned AddrWidth     = 16,
    parameter int unsigned NumPE_M       = 4,
    parameter int unsigned NumPE_N       = 4,
    parameter int unsigned NumIp_K       = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [SizeAddrWidth-1:0] M_size_i,
    input  logic [SizeAddrWidth-1:0] K_size_i,
    input  logic [SizeAddrWidth-1:0] N_size_i,
    input  logic                     stall_i,
    output logic [AddrWidth-1:0]     sram_a_addr_o,
    output logic [AddrWidth-1:0]     sram_b_addr_o,
    output logic [AddrWidth-1:0]     sram_c_addr_o,
    output logic                     sram_c_we_o,
    output logic                     pe_valid_o,
    output logic                     pe_init_save_o,
    output logic                     pe_acc_clr_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int unsigned ShM = $clog2(NumPE_M);
    localparam int unsigned ShN = $clog2(NumPE_N);
    localparam int unsigned ShK = $clog2(NumIp_K);
    localparam logic [SizeAddrWidth-1:0] One = SizeAddrWidth'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e                   state_q;
    logic [SizeAddrWidth-1:0] mt_q, kt_q, nt_q;
    logic [SizeAddrWidth-1:0] m_q, n_q, k_q;
    logic [SizeAddrWidth-1:0] m_d, n_d, k_d;
    logic [SizeAddrWidth-1:0] mt_d, kt_d, nt_d;
    logic                     issue_d, tile_end_d, last_issue_d;
    logic                     drain_q;
    logic [AddrWidth-1:0]     a_addr_q, b_addr_q, c_addr_q, c_addr_p_q;
    logic                     we_p_q, we_q, valid_q, init_q;

    // hi*stride + lo, unsigned, truncated to AddrWidth
    function automatic logic [AddrWidth-1:0] lin(input logic [SizeAddrWidth-1:0] hi,
                                                 input logic [SizeAddrWidth-1:0] stride,
                                                 input logic [SizeAddrWidth-1:0] lo);
        logic [AddrWidth-1:0] h, s, l;
        h = AddrWidth'(hi);
        s = AddrWidth'(stride);
        l = AddrWidth'(lo);
        return h * s + l;
    endfunction

    always_comb begin
        mt_d         = M_size_i >> ShM;
        kt_d         = K_size_i >> ShK;
        nt_d         = N_size_i >> ShN;
        issue_d      = (state_q == RUN) && !stall_i;
        tile_end_d   = (k_q == kt_q - One);
        last_issue_d = tile_end_d && (n_q == nt_q - One) && (m_q == mt_q - One);
        m_d          = m_q;
        n_d          = n_q;
        k_d          = k_q + One;
        if (tile_end_d) begin
            k_d = '0;
            if (n_q == nt_q - One) begin
                n_d = '0;
                m_d = m_q + One;
            end else begin
                n_d = n_q + One;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            mt_q       <= '0;
            kt_q       <= '0;
            nt_q       <= '0;
            m_q        <= '0;
            n_q        <= '0;
            k_q        <= '0;
            drain_q    <= 1'b0;
            a_addr_q   <= '0;
            b_addr_q   <= '0;
            c_addr_q   <= '0;
            c_addr_p_q <= '0;
            we_p_q     <= 1'b0;
            we_q       <= 1'b0;
            valid_q    <= 1'b0;
            init_q     <= 1'b0;
        end else begin
            // Read-data alignment: valid/init one cycle after issue, C write two.
            valid_q <= issue_d;
            init_q  <= issue_d && (k_q == '0);
            we_p_q  <= issue_d && tile_end_d;
            if (issue_d && tile_end_d) c_addr_p_q <= lin(m_q, nt_q, n_q);
            we_q    <= we_p_q;
            if (we_p_q) c_addr_q <= c_addr_p_q;

            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        mt_q     <= mt_d;
                        kt_q     <= kt_d;
                        nt_q     <= nt_d;
                        m_q      <= '0;
                        n_q      <= '0;
                        k_q      <= '0;
                        a_addr_q <= '0;
                        b_addr_q <= '0;
                        if (mt_d == '0 || kt_d == '0 || nt_d == '0) state_q <= DONE;
                        else                                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (issue_d) begin
                        if (last_issue_d) begin
                            state_q <= DRAIN;
                            drain_q <= 1'b0;
                        end else begin
                            m_q      <= m_d;
                            n_q      <= n_d;
                            k_q      <= k_d;
                            a_addr_q <= lin(m_d, kt_q, k_d);
                            b_addr_q <= lin(n_d, kt_q, k_d);
                        end
                    end
                end
                DRAIN: begin
                    drain_q <= 1'b1;
                    if (drain_q) state_q <= DONE;
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sram_a_addr_o  = a_addr_q;
    assign sram_b_addr_o  = b_addr_q;
    assign sram_c_addr_o  = c_addr_q;
    assign sram_c_we_o    = we_q;
    assign pe_valid_o     = valid_q;
    assign pe_init_save_o = init_q;
    assign pe_acc_clr_o   = (state_q == IDLE) || (state_q == DONE);
    assign busy_o         = (state_q == RUN) || (state_q == DRAIN);
    assign done_o         = (state_q == DONE);

endmodule
